// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-style control FSM.
// Ports: clk, rst_n (async, active-low); instr_opcode, mem_ack in;
// datapath controls, alu_op, state (debug), instr_done, instr_count, trap out.
module multicycle_control #(
    parameter int ALU_OP_W = 2,
    parameter int CNT_W    = 32,
    parameter int IMM_EN   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          instr_opcode,
    input  logic                mem_ack,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [3:0]          state,
    output logic                instr_done,
    output logic [CNT_W-1:0]    instr_count,
    output logic                trap
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_EXEC = 4'd6, S_ALUWB = 4'd7,
        S_BRANCH = 4'd8, S_ADDIEXEC = 4'd9, S_ADDIWB = 4'd10, S_JUMP = 4'd11,
        S_TRAP = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       w_alu_op;
    logic             w_addi_ok;

    assign w_addi_ok   = (IMM_EN != 0) && (instr_opcode == OP_ADDI);
    assign state       = r_state;
    assign instr_count = r_count;
    assign alu_op      = ALU_OP_W'(w_alu_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (instr_done) r_count <= r_count + 1'b1;
        end
    end

    // Everything, including the retire pulse, is held at 0 while reset is asserted.
    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        w_alu_op      = 2'b00;
        instr_done    = 1'b0;
        trap          = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ack;
                    pc_write  = mem_ack;
                    w_next    = mem_ack ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    w_next    = (instr_opcode == OP_LW || instr_opcode == OP_SW) ? S_MEMADR :
                                (instr_opcode == OP_R)   ? S_EXEC :
                                (instr_opcode == OP_BEQ) ? S_BRANCH :
                                (instr_opcode == OP_J)   ? S_JUMP :
                                w_addi_ok                ? S_ADDIEXEC : S_TRAP;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    w_next    = (instr_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    w_next   = mem_ack ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ack;
                    w_next     = mem_ack ? S_FETCH : S_MEMWR;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    w_alu_op  = 2'b10;
                    w_next    = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    w_alu_op      = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                    w_next        = S_FETCH;
                end
                S_ADDIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    w_next    = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
                // TRAP is terminal; unused encodings fall into it as well.
                default: begin
                    trap   = (r_state == S_TRAP);
                    w_next = S_TRAP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream against a sequence-level reference model.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst_n, ack;
    logic [5:0] opcode;
    int total = 0, bad = 0;

    logic pw, pwc, io, irw, mr, mw, m2r, rd, rw, sa, done, trp;
    logic [1:0] sb, ps, ao;
    logic [3:0] st, cnt;
    logic b_pw, b_pwc, b_io, b_irw, b_mr, b_mw, b_m2r, b_rd, b_rw, b_sa, b_done, b_trp;
    logic [1:0] b_sb, b_ps, b_ao;
    logic [3:0] b_st, b_cnt;
    logic [16:0] obs, b_obs;

    assign obs   = {pw, pwc, io, irw, mr, mw, m2r, rd, rw, sa, sb, ps, ao, trp};
    assign b_obs = {b_pw, b_pwc, b_io, b_irw, b_mr, b_mw, b_m2r, b_rd, b_rw, b_sa, b_sb, b_ps, b_ao, b_trp};

    multicycle_control #(.ALU_OP_W(2), .CNT_W(4), .IMM_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_opcode(opcode), .mem_ack(ack),
        .pc_write(pw), .pc_write_cond(pwc), .iord(io), .ir_write(irw),
        .mem_read(mr), .mem_write(mw), .mem_to_reg(m2r), .reg_dst(rd),
        .reg_write(rw), .alu_src_a(sa), .alu_src_b(sb), .pc_source(ps),
        .alu_op(ao), .state(st), .instr_done(done), .instr_count(cnt), .trap(trp));

    multicycle_control #(.ALU_OP_W(2), .CNT_W(4), .IMM_EN(0)) dut_noimm (
        .clk(clk), .rst_n(rst_n), .instr_opcode(6'b001000), .mem_ack(ack),
        .pc_write(b_pw), .pc_write_cond(b_pwc), .iord(b_io), .ir_write(b_irw),
        .mem_read(b_mr), .mem_write(b_mw), .mem_to_reg(b_m2r), .reg_dst(b_rd),
        .reg_write(b_rw), .alu_src_a(b_sa), .alu_src_b(b_sb), .pc_source(b_ps),
        .alu_op(b_ao), .state(b_st), .instr_done(b_done), .instr_count(b_cnt), .trap(b_trp));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control bundle for a named step of an instruction (same packing as obs).
    function automatic logic [16:0] ctrl_of(input int step, input logic a);
        logic [16:0] v;
        v = '0;
        case (step)
            0:  v = {3'b000, a, 1'b1, 5'b00000, 2'b01, 2'b00, 2'b00, 1'b0} | (17'(a) << 16);
            1:  v = {10'b0, 2'b11, 2'b00, 2'b00, 1'b0};
            2:  v = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
            3:  v = {2'b00, 1'b1, 1'b0, 1'b1, 5'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            4:  v = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0};
            5:  v = {2'b00, 1'b1, 2'b00, 1'b1, 4'b0, 7'b0};
            6:  v = {9'b0, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0};
            7:  v = {7'b0, 1'b1, 1'b1, 1'b0, 7'b0};
            8:  v = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
            9:  v = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
            10: v = {8'b0, 1'b1, 1'b0, 7'b0};
            11: v = {1'b1, 11'b0, 2'b10, 2'b00, 1'b0};
            15: v = 17'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    initial begin
        logic [5:0] ops [6];
        int seq[$];
        int cycles, exp_cnt, pos, stp;
        logic adv, last;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
        rst_n = 1'b1; ack = 1'b1; opcode = 6'b100011;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(st), 0);
        check("reset_ctrl", 32'(obs), 0);
        check("reset_done", 32'(done), 0);
        check("reset_count", 32'(cnt), 0);
        @(negedge clk);
        ack = 1'b0;
        rst_n = 1'b1;
        #1 check("release_ctrl", 32'(obs), 32'(ctrl_of(0, 1'b0)));
        exp_cnt = 0;
        cycles = 0;
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 5)];
            case (op)
                6'b100011: seq = '{0, 1, 2, 3, 4};
                6'b101011: seq = '{0, 1, 2, 5};
                6'b000000: seq = '{0, 1, 6, 7};
                6'b001000: seq = '{0, 1, 9, 10};
                6'b000100: seq = '{0, 1, 8};
                default:   seq = '{0, 1, 11};
            endcase
            pos = 0;
            while (pos < seq.size()) begin
                @(negedge clk);
                opcode = op;
                ack = ($urandom_range(0, 3) != 0);
                #1;
                stp = seq[pos];
                adv = !(stp == 0 || stp == 3 || stp == 5) || ack;
                last = adv && (pos == seq.size() - 1);
                check("state", 32'(st), 32'(stp));
                check("ctrl", 32'(obs), 32'(ctrl_of(stp, ack)));
                check("done", 32'(done), 32'(last));
                check("count", 32'(cnt), 32'(exp_cnt));
                if (last) exp_cnt = (exp_cnt + 1) % 16;
                if (adv) pos++;
                cycles++;
                if (cycles > 20000) begin
                    $display("FAIL cycle_budget got=%0d exp<=20000", cycles);
                    $fatal(1, "cycle budget exhausted");
                end
            end
        end
        @(negedge clk);
        #1 check("count_final", 32'(cnt), 32'(exp_cnt));
        opcode = 6'b101011;
        ack = 1'b1;
        repeat (3) @(negedge clk);
        ack = 1'b0;
        #1;
        check("sw_wait_state", 32'(st), 5);
        check("sw_wait_memwrite", 32'(mw), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_state", 32'(st), 0);
        check("abort_ctrl", 32'(obs), 0);
        check("abort_done", 32'(done), 0);
        @(posedge clk);
        #1;
        check("abort_count", 32'(cnt), 0);
        check("abort_hold_done", 32'(done), 0);
        @(negedge clk);
        opcode = 6'b111111;
        ack = 1'b1;
        rst_n = 1'b1;
        #1;
        check("trap_fetch", 32'(st), 0);
        check("noimm_fetch", 32'(b_st), 0);
        @(negedge clk);
        #1;
        check("trap_decode", 32'(st), 1);
        check("noimm_decode", 32'(b_st), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ack = k[0];
            #1;
            check("trap_state", 32'(st), 15);
            check("trap_ctrl", 32'(obs), 1);
            check("trap_done", 32'(done), 0);
            check("trap_count", 32'(cnt), 0);
            check("noimm_state", 32'(b_st), 15);
            check("noimm_ctrl", 32'(b_obs), 1);
            check("noimm_count", 32'(b_cnt), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_OP_W SHALL default to 2 and set the alu_op width; values below 2 are illegal.
REQ-002 Parameter CNT_W SHALL default to 32 and set the instr_count width.
REQ-003 Parameter IMM_EN SHALL default to 1; when 1, addi (6'b001000) is decoded; when 0, addi is treated as illegal.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 instr_opcode  in  6  opcode field of the instruction register.
REQ-007 mem_ack  in  1  memory completion for the current mem_read/mem_write request.
REQ-008 pc_write, pc_write_cond, iord, ir_write  out  1 each  PC update, conditional PC update, data-address select, instruction-register load.
REQ-009 mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
REQ-010 alu_src_b  out  2  ALU B select (00 reg, 01 const 4, 10 sign-ext imm, 11 shifted imm).
REQ-011 pc_source  out  2  PC mux (00 ALU, 01 ALUOut, 10 jump target).
REQ-012 alu_op  out  ALU_OP_W  00 add, 01 sub, 10 funct-decoded; upper bits always 0.
REQ-013 state  out  4  current state encoding, for debug.
REQ-014 instr_done  out  1  one-cycle pulse on instruction retire.
REQ-015 instr_count  out  CNT_W  retired-instruction counter.
REQ-016 trap  out  1  high while in TRAP.

Function
REQ-017 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, TRAP=15.
REQ-018 All control outputs not listed for a state SHALL be 0.
REQ-019 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add; hold FETCH while mem_ack=0.
REQ-020 FETCH with mem_ack=1: additionally ir_write=1, pc_write=1, pc_source=00, in that cycle only; next state DECODE.
REQ-021 DECODE: alu_src_a=0, alu_src_b=11, alu_op=add; next state by opcode: lw/sw->MEMADR, R-type(0)->EXEC, beq(000100)->BRANCH, j(000010)->JUMP, addi with IMM_EN=1->ADDIEXEC, any other->TRAP.
REQ-022 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add; next MEMRD for lw, MEMWR for sw.
REQ-023 MEMRD: mem_read=1, iord=1; hold until mem_ack=1, then MEMWB.
REQ-024 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; retire -> FETCH.
REQ-025 MEMWR: mem_write=1, iord=1; hold until mem_ack=1, then retire -> FETCH.
REQ-026 EXEC: alu_src_a=1, alu_src_b=00, alu_op=funct -> ALUWB; ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; retire -> FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_source=01; retire -> FETCH.
REQ-028 JUMP: pc_write=1, pc_source=10; retire -> FETCH.
REQ-029 ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=add -> ADDIWB; ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; retire -> FETCH.
REQ-030 Retire SHALL mean: instr_done=1 for that cycle and instr_count increments by 1 at the clock edge, wrapping from all-ones to 0.
REQ-031 TRAP: all controls 0, trap=1, no retire; remains in TRAP until reset.
REQ-032 Outputs SHALL be combinational from state, opcode and mem_ack only; mem_ack is ignored outside FETCH, MEMRD and MEMWR.
REQ-033 Latency with mem_ack tied high SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each cycle mem_ack is low in a wait state adds exactly 1 cycle.

Reset
REQ-034 With rst_n=0: state=FETCH, instr_count=0, trap=0, instr_done=0; FETCH outputs (mem_read=1) are driven during reset only after rst_n releases.
REQ-035 During reset all control outputs SHALL be 0.
REQ-036 Reset asserted mid-instruction, including during a wait state, SHALL abort it immediately with no retire or count update.
REQ-037 The first clock edge after rst_n rises SHALL evaluate FETCH normally.

Verification
REQ-038 lw, mem_ack=1 throughout -> states 0,1,2,3,4; reg_write and mem_to_reg high in cycle 5; instr_count 0->1.
REQ-039 Fetch mem_ack low for 2 cycles, then R-type -> FETCH held 3 cycles, ir_write/pc_write high only in the 3rd; 6 cycles total.
REQ-040 beq then j -> pc_write_cond=1, alu_op=01 in BRANCH; pc_source=10 in JUMP; instr_count=2 after 6 cycles.
REQ-041 Opcode 6'b111111, or addi with IMM_EN=0 -> TRAP after DECODE; trap=1 held for 10 cycles; count unchanged.
REQ-042 rst_n pulsed low in MEMWR while waiting -> state=0 asynchronously, mem_write=0, no instr_done.
REQ-043 CNT_W=4, retire 17 instructions -> instr_count=1.
